wb_trace_buffer: RTL

//  Captures one architectural writeback event per clock after warm-up: GPR write, HI/LO write,
//  CP0 write or skip. Stores each event in a FIFO for the unit-test bench or a debug UART.

---
 rtl/wb_trace_buffer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_trace_buffer.sv
// ============================================================================
// Module   : wb_trace_buffer
// Purpose  : Captures one architectural writeback event per clock (GPR, HI/LO,
//            CP0 or skip) after a warm-up period. Each event is stamped with a
//            sequence number and queued in a show-ahead FIFO for a golden-trace
//            compare or a debug UART.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_trace_buffer #(
    parameter int DEPTH  = 16,   // power of two, >= 2
    parameter int WARMUP = 5,    // >= 1
    parameter int SEQ_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,          // synchronous, active-low
    input  logic                     trace_en_i,
    input  logic                     reg_we_i,
    input  logic [4:0]               reg_waddr_i,
    input  logic [31:0]              reg_wdata_i,
    input  logic                     hilo_we_i,
    input  logic [31:0]              hi_data_i,
    input  logic [31:0]              lo_data_i,
    input  logic                     cp0_we_i,
    input  logic [4:0]               cp0_waddr_i,
    input  logic [31:0]              cp0_wdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [1:0]               out_kind_o,
    output logic [SEQ_W-1:0]         out_seq_o,
    output logic [4:0]               out_addr_o,
    output logic [31:0]              out_data0_o,
    output logic [31:0]              out_data1_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_WARM_W = (WARMUP < 2) ? 1 : $clog2(WARMUP);

    localparam logic [1:0] c_KIND_SKIP = 2'd0;
    localparam logic [1:0] c_KIND_GPR  = 2'd1;
    localparam logic [1:0] c_KIND_HILO = 2'd2;
    localparam logic [1:0] c_KIND_CP0  = 2'd3;

    typedef enum logic [1:0] {
        ST_WARM = 2'd0,
        ST_RUN  = 2'd1,
        ST_IDLE = 2'd2
    } state_t;

    state_t               state_q;
    logic [c_WARM_W-1:0]  warm_q;
    logic [SEQ_W-1:0]     seq_q;
    logic [c_PTR_W-1:0]   wr_ptr_q;
    logic [c_PTR_W-1:0]   rd_ptr_q;
    logic [c_CNT_W-1:0]   count_q;
    logic [c_CNT_W-1:0]   count_d;
    logic                 overflow_q;
    logic [15:0]          drop_cnt_q;
    logic [15:0]          drop_cnt_d;

    // Entry storage; not reset because every read is qualified by a non-zero count.
    logic [1:0]           kind_mem_q  [DEPTH];
    logic [SEQ_W-1:0]     seq_mem_q   [DEPTH];
    logic [4:0]           addr_mem_q  [DEPTH];
    logic [31:0]          data0_mem_q [DEPTH];
    logic [31:0]          data1_mem_q [DEPTH];

    logic [1:0]           w_kind;
    logic [4:0]           w_addr;
    logic [31:0]          w_data0;
    logic [31:0]          w_data1;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic [SEQ_W-1:0]     w_seq_next;

    // Fixed-priority event classification: GPR over HI/LO over CP0 over skip.
    always_comb begin
        w_kind  = c_KIND_SKIP;
        w_addr  = 5'd0;
        w_data0 = 32'd0;
        w_data1 = 32'd0;
        if (reg_we_i) begin
            w_kind  = c_KIND_GPR;
            w_addr  = reg_waddr_i;
            w_data0 = reg_wdata_i;
        end else if (hilo_we_i) begin
            w_kind  = c_KIND_HILO;
            w_data0 = hi_data_i;
            w_data1 = lo_data_i;
        end else if (cp0_we_i) begin
            w_kind  = c_KIND_CP0;
            w_addr  = cp0_waddr_i;
            w_data0 = cp0_wdata_i;
        end
    end

    assign w_capture  = (state_q == ST_RUN) && trace_en_i;
    assign w_pop      = (count_q != '0) && out_ready_i;
    assign w_full     = (count_q == c_CNT_W'(DEPTH));
    // A full FIFO still accepts an event when the head leaves in the same cycle.
    assign w_push     = w_capture && (!w_full || w_pop);
    assign w_drop     = w_capture && !w_push;
    assign w_seq_next = seq_q + 1'b1;

    // Next-state values for occupancy and the saturating drop counter.
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end
        drop_cnt_d = drop_cnt_q;
        if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Capture FSM, sequence numbering, FIFO pointers and overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_WARM;
            warm_q     <= '0;
            seq_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            case (state_q)
                ST_WARM: begin
                    if (trace_en_i) begin
                        if (warm_q == c_WARM_W'(WARMUP - 1)) begin
                            state_q <= ST_RUN;
                            warm_q  <= '0;
                        end else begin
                            warm_q  <= warm_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!trace_en_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (trace_en_i) begin
                        state_q <= ST_WARM;
                        warm_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_WARM;
                    warm_q  <= '0;
                end
            endcase

            // Sequence advances for every recorded event, dropped or not.
            if (w_capture) begin
                seq_q <= w_seq_next;
            end
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_drop) begin
                overflow_q <= 1'b1;
            end
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Entry write port.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            kind_mem_q[wr_ptr_q]  <= w_kind;
            seq_mem_q[wr_ptr_q]   <= w_seq_next;
            addr_mem_q[wr_ptr_q]  <= w_addr;
            data0_mem_q[wr_ptr_q] <= w_data0;
            data1_mem_q[wr_ptr_q] <= w_data1;
        end
    end

    // Show-ahead head presentation, forced to zero while empty.
    assign out_valid_o  = (count_q != '0);
    assign out_kind_o   = out_valid_o ? kind_mem_q[rd_ptr_q]  : 2'd0;
    assign out_seq_o    = out_valid_o ? seq_mem_q[rd_ptr_q]   : '0;
    assign out_addr_o   = out_valid_o ? addr_mem_q[rd_ptr_q]  : 5'd0;
    assign out_data0_o  = out_valid_o ? data0_mem_q[rd_ptr_q] : 32'd0;
    assign out_data1_o  = out_valid_o ? data1_mem_q[rd_ptr_q] : 32'd0;
    assign fifo_count_o = count_q;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

`default_nettype wire
